// File: rtl/wb_stage.sv
// Write-back stage: merges memory-stage and MDU results onto the single
// register-file write port. A one-entry hold buffer absorbs collisions between the two sources.
module wb_stage #(
  parameter int WORD_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [ADDR_WIDTH-1:0] mem_rd_i,
  input  logic                  mem_wen_i,
  input  logic                  mem_load_i,
  input  logic [2:0]            load_type_i,
  input  logic [1:0]            byte_off_i,
  input  logic [WORD_WIDTH-1:0] alu_result_i,
  input  logic [WORD_WIDTH-1:0] mem_rdata_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [ADDR_WIDTH-1:0] mdu_rd_i,
  input  logic [WORD_WIDTH-1:0] mdu_result_i,
  output logic [ADDR_WIDTH-1:0] reg_waddr_o,
  output logic [WORD_WIDTH-1:0] reg_wdata_o,
  output logic                  reg_wen_o,
  output logic                  misalign_o,
  output logic [31:0]           wb_count_o
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [WORD_WIDTH-1:0] data;
  } wb_req_t;

  logic            hold_valid;
  wb_req_t         hold_q;
  wb_req_t         mem_req, wr_d;
  logic            wen_d, hold_set;
  logic            mem_acc, mdu_acc, mem_bad, mem_wr, mdu_wr;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [WORD_WIDTH-1:0] ld_data;
  logic            ld_ok;

  // Ready depends only on hold state, so there is no input-to-ready path.
  assign mem_ready_o = !hold_valid;
  assign mdu_ready_o = !hold_valid;

  always_comb begin
    case (byte_off_i)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = byte_off_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_ok   = 1'b0;
    ld_data = mem_rdata_i;
    case (load_type_i)
      3'b000: begin ld_ok = 1'b1;             ld_data = {{(WORD_WIDTH-8){ld_byte[7]}}, ld_byte}; end
      3'b100: begin ld_ok = 1'b1;             ld_data = {{(WORD_WIDTH-8){1'b0}}, ld_byte}; end
      3'b001: begin ld_ok = !byte_off_i[0];   ld_data = {{(WORD_WIDTH-16){ld_half[15]}}, ld_half}; end
      3'b101: begin ld_ok = !byte_off_i[0];   ld_data = {{(WORD_WIDTH-16){1'b0}}, ld_half}; end
      3'b010: begin ld_ok = (byte_off_i == 2'd0); ld_data = mem_rdata_i; end
      default: begin ld_ok = 1'b0;            ld_data = mem_rdata_i; end
    endcase
  end

  assign mem_bad      = mem_load_i && !ld_ok;
  assign mem_req.rd   = mem_rd_i;
  assign mem_req.data = mem_load_i ? ld_data : alu_result_i;
  assign mem_acc      = mem_valid_i && !hold_valid;
  assign mdu_acc      = mdu_valid_i && !hold_valid;
  // Suppressed or misaligned results are consumed without claiming the port.
  assign mem_wr       = mem_acc && mem_wen_i && (mem_rd_i != '0) && !mem_bad;
  assign mdu_wr       = mdu_acc && (mdu_rd_i != '0);

  always_comb begin
    wen_d    = 1'b0;
    wr_d     = hold_q;
    hold_set = 1'b0;
    if (hold_valid) begin
      wen_d = 1'b1;
      wr_d  = hold_q;
    end else if (mdu_wr) begin
      wen_d     = 1'b1;
      wr_d.rd   = mdu_rd_i;
      wr_d.data = mdu_result_i;
      hold_set  = mem_wr;
    end else if (mem_wr) begin
      wen_d = 1'b1;
      wr_d  = mem_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid  <= 1'b0;
      hold_q      <= '0;
      reg_waddr_o <= '0;
      reg_wdata_o <= '0;
      reg_wen_o   <= 1'b0;
      misalign_o  <= 1'b0;
      wb_count_o  <= '0;
    end else begin
      hold_valid <= hold_set;
      if (hold_set) hold_q <= mem_req;
      reg_wen_o  <= wen_d;
      if (wen_d) begin
        reg_waddr_o <= wr_d.rd;
        reg_wdata_o <= wr_d.data;
      end
      misalign_o <= mem_acc && mem_bad;
      wb_count_o <= wb_count_o + {31'd0, wen_d};
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: a bench-side model predicts acceptance, hold state and
// writes; expected writes are queued at drive time and popped when the DUT writes.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid_i = 1'b0, mem_wen_i = 1'b0, mem_load_i = 1'b0;
  logic [4:0]  mem_rd_i = '0, mdu_rd_i = '0;
  logic [2:0]  load_type_i = '0;
  logic [1:0]  byte_off_i = '0;
  logic [31:0] alu_result_i = '0, mem_rdata_i = '0, mdu_result_i = '0;
  logic        mdu_valid_i = 1'b0;
  logic        mem_ready_o, mdu_ready_o, reg_wen_o, misalign_o;
  logic [4:0]  reg_waddr_o;
  logic [31:0] reg_wdata_o, wb_count_o;

  wb_stage #(.WORD_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o), .mem_rd_i(mem_rd_i),
    .mem_wen_i(mem_wen_i), .mem_load_i(mem_load_i), .load_type_i(load_type_i),
    .byte_off_i(byte_off_i), .alu_result_i(alu_result_i), .mem_rdata_i(mem_rdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o), .mdu_rd_i(mdu_rd_i),
    .mdu_result_i(mdu_result_i), .reg_waddr_o(reg_waddr_o), .reg_wdata_o(reg_wdata_o),
    .reg_wen_o(reg_wen_o), .misalign_o(misalign_o), .wb_count_o(wb_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          n_chk = 0, n_err = 0;
  logic        h = 1'b0;         // model of hold_valid
  logic [31:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every DUT write must match the oldest expected write.
  always @(negedge clk) begin
    if (reg_wen_o === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_wen", 32'd1, 32'd0);
      else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wb_addr", {27'd0, reg_waddr_o}, {27'd0, e.a});
        chk("wb_data", reg_wdata_o, e.d);
      end
    end
  end

  function automatic void load_model(input logic [2:0] ty, input logic [1:0] off,
                                     input logic [31:0] rd, output logic ok,
                                     output logic [31:0] d);
    logic [31:0] b, hw;
    b  = (rd >> (8 * off)) & 32'hFF;
    hw = (rd >> (16 * off[1])) & 32'hFFFF;
    ok = 1'b0;
    d  = 32'h0;
    case (ty)
      3'b000: begin ok = 1'b1; d = b[7] ? (b | 32'hFFFFFF00) : b; end
      3'b100: begin ok = 1'b1; d = b; end
      3'b001: begin ok = (off[0] == 1'b0); d = hw[15] ? (hw | 32'hFFFF0000) : hw; end
      3'b101: begin ok = (off[0] == 1'b0); d = hw; end
      3'b010: begin ok = (off == 2'd0); d = rd; end
      default: ok = 1'b0;
    endcase
  endfunction

  // One cycle of stimulus; checks misalign, ready and counter afterwards.
  task automatic drive(input logic mv, input logic [4:0] rd, input logic wen,
                       input logic ld, input logic [2:0] ty, input logic [1:0] off,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic dv, input logic [4:0] drd, input logic [31:0] dres);
    logic ok, mem_w, mdu_w, exp_mis;
    logic [31:0] ld_d;
    wr_t w;
    mem_valid_i = mv; mem_rd_i = rd; mem_wen_i = wen; mem_load_i = ld;
    load_type_i = ty; byte_off_i = off; alu_result_i = alu; mem_rdata_i = rdata;
    mdu_valid_i = dv; mdu_rd_i = drd; mdu_result_i = dres;
    load_model(ty, off, rdata, ok, ld_d);
    exp_mis = 1'b0;
    if (h) begin
      h = 1'b0;
      exp_cnt++;
    end else begin
      if (!ld) ok = 1'b1;
      mdu_w   = dv && (drd != 5'd0);
      mem_w   = mv && wen && (rd != 5'd0) && ok;
      exp_mis = mv && ld && !ok;
      if (mdu_w) begin w.a = drd; w.d = dres; exp_q.push_back(w); exp_cnt++; end
      if (mem_w) begin
        w.a = rd; w.d = ld ? ld_d : alu; exp_q.push_back(w);
        if (mdu_w) h = 1'b1; else exp_cnt++;
      end
    end
    @(negedge clk);
    mem_valid_i = 1'b0; mdu_valid_i = 1'b0;
    chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
    chk("mem_ready", {31'd0, mem_ready_o}, {31'd0, !h});
    chk("mdu_ready", {31'd0, mdu_ready_o}, {31'd0, !h});
    chk("wb_count", wb_count_o, exp_cnt);
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic alu_op(input logic [4:0] rd, input logic [31:0] v);
    drive(1'b1, rd, 1'b1, 1'b0, 3'd0, 2'd0, v, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic load_op(input logic [4:0] rd, input logic [2:0] ty, input logic [1:0] off);
    drive(1'b1, rd, 1'b1, 1'b1, ty, off, 32'hDEAD_BEEF, 32'h80F1_7F02, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_wen", {31'd0, reg_wen_o}, 32'd0);
    chk("rst_addr", {27'd0, reg_waddr_o}, 32'd0);
    chk("rst_data", reg_wdata_o, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    chk("rst_cnt", wb_count_o, 32'd0);
    chk("rst_mem_ready", {31'd0, mem_ready_o}, 32'd1);
    chk("rst_mdu_ready", {31'd0, mdu_ready_o}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    alu_op(5'd7, 32'h1234_5678);
    idle();

    load_op(5'd1, 3'b000, 2'd3);
    load_op(5'd2, 3'b100, 2'd2);
    load_op(5'd3, 3'b001, 2'd2);
    load_op(5'd4, 3'b101, 2'd0);
    load_op(5'd5, 3'b010, 2'd0);
    load_op(5'd6, 3'b000, 2'd1);
    load_op(5'd8, 3'b101, 2'd2);
    idle();

    load_op(5'd5, 3'b010, 2'd1);
    idle();
    load_op(5'd5, 3'b001, 2'd3);
    load_op(5'd6, 3'b011, 2'd0);
    load_op(5'd6, 3'b111, 2'd0);
    load_op(5'd6, 3'b101, 2'd1);
    idle();

    // collision, then drain
    drive(1'b1, 5'd4, 1'b1, 1'b0, 3'd0, 2'd0, 32'hB, 32'd0, 1'b1, 5'd3, 32'hA);
    idle();
    idle();

    // suppressed memory result colliding with MDU
    drive(1'b1, 5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h55, 32'd0, 1'b1, 5'd9, 32'h99);
    idle();
    drive(1'b1, 5'd12, 1'b0, 1'b0, 3'd0, 2'd0, 32'h66, 32'd0, 1'b1, 5'd0, 32'h77);
    drive(1'b0, 5'd0, 1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 32'd0, 1'b1, 5'd13, 32'hC0DE);
    idle();

    // sustained collisions from both sources
    for (int i = 0; i < 6; i++)
      drive(1'b1, 5'(10 + i), 1'b1, 1'b0, 3'd0, 2'd0, 32'(100 + i), 32'd0,
            1'b1, 5'(20 + i), 32'(200 + i));
    idle();
    idle();

    // reset while the hold buffer is occupied
    drive(1'b1, 5'd17, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1717, 32'd0, 1'b1, 5'd18, 32'h1818);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wen", {31'd0, reg_wen_o}, 32'd0);
    chk("arst_addr", {27'd0, reg_waddr_o}, 32'd0);
    chk("arst_data", reg_wdata_o, 32'd0);
    chk("arst_cnt", wb_count_o, 32'd0);
    chk("arst_ready", {31'd0, mem_ready_o & mdu_ready_o}, 32'd1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    h = 1'b0;
    exp_cnt = '0;
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    idle();
    idle();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage: the producer side of the register-file write port that the decode stage consumes through `reg_waddr_i`, `reg_wdata_i` and `reg_wen_i`. It does three things:
- Accepts retiring results from the memory stage and from the multi-cycle MDU.
- Extracts and extends load data by load type and byte offset.
- Arbitrates the single write port, then drives it from registered outputs.

A one-entry hold buffer absorbs collisions between the two sources. Upstream is back-pressured while that buffer is occupied.

## Interface
- `WORD_WIDTH`, 32, data width; only 32 is supported.
- `ADDR_WIDTH`, 5, register address width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mem_valid_i`  in  1  memory-stage result presented this cycle.
- `mem_ready_o`  out  1  stage can accept a memory-stage result; equals `!hold_valid`.
- `mem_rd_i`  in  ADDR_WIDTH  destination register.
- `mem_wen_i`  in  1  instruction writes rd.
- `mem_load_i`  in  1  result is load data, not ALU data.
- `load_type_i`  in  3  load type as funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101.
- `byte_off_i`  in  2  address bits [1:0] of the load.
- `alu_result_i`  in  WORD_WIDTH  ALU result.
- `mem_rdata_i`  in  WORD_WIDTH  raw aligned data word from memory.
- `mdu_valid_i`  in  1  MDU result available.
- `mdu_ready_o`  out  1  MDU result accepted this cycle.
- `mdu_rd_i`  in  ADDR_WIDTH  MDU destination register.
- `mdu_result_i`  in  WORD_WIDTH  MDU result.
- `reg_waddr_o`  out  ADDR_WIDTH  register-file write address.
- `reg_wdata_o`  out  WORD_WIDTH  register-file write data.
- `reg_wen_o`  out  1  register-file write enable.
- `misalign_o`  out  1  one-cycle pulse: a load was dropped as misaligned.
- `wb_count_o`  out  32  count of committed register writes.

## Operation
**Acceptance**
- A memory-stage result is accepted when `mem_valid_i && mem_ready_o`.
- An MDU result is accepted when `mdu_valid_i && mdu_ready_o`.
- `mdu_ready_o = !hold_valid`. `mdu_ready_o` is valid combinationally in the same cycle as `mdu_valid_i`.

**Write-port priority:** hold buffer > MDU > memory stage.
- Hold buffer occupied: the hold entry is written. Both ready outputs are low, so no new input is taken.
- Hold empty, both sources valid: the MDU result is written. The memory result is processed into the hold buffer, and `hold_valid` is set.
- Hold empty, only one source valid: that source is written.

**Load data**, where `off` is `byte_off_i`:
- LB: `sext(rdata[8*off+:8])`.
- LBU: `zext(rdata[8*off+:8])`.
- LH: `sext(rdata[16*off[1]+:16])`.
- LHU: `zext(rdata[16*off[1]+:16])`.
- LW: the full word.

**Misaligned loads**
- A load is misaligned when it is LH/LHU with `off[0]=1`, or LW with `off!=0`.
- A misaligned load produces no write and pulses `misalign_o`.
- This is decided at acceptance: a misaligned memory result is never placed in the hold buffer.
- The same applies to undefined `load_type_i` codes (011, 110, 111): no write, `misalign_o` pulse.

**Write suppression**
- A result with rd=0, or a memory result with `mem_wen_i=0`, produces `reg_wen_o=0`.
- Such a result still consumes its slot: it is accepted and does not occupy the write port.
- A suppressed memory result colliding with an MDU result is discarded, not held, and `hold_valid` stays 0.

**Counter:** `wb_count_o` increments on every cycle that `reg_wen_o` is 1, and wraps from 0xFFFFFFFF to 0.

## Timing
**Latency**
- An accepted result appears on `reg_*_o` in the cycle after acceptance.
- A held result appears one cycle after the cycle in which it was written into the hold buffer.

**Registered outputs:** `reg_waddr_o`, `reg_wdata_o`, `reg_wen_o`, `misalign_o`, `wb_count_o`.
- `reg_wen_o` is high for exactly one cycle per committed write.
- `reg_waddr_o` and `reg_wdata_o` keep their last values when `reg_wen_o=0`.

**Ready outputs:** `mem_ready_o` and `mdu_ready_o` are combinational from `hold_valid` only. There is no input-to-ready path.

**Reset (`rst_n` low, asynchronous)**
- Output values: `reg_waddr_o`=0, `reg_wdata_o`=0, `reg_wen_o`=0, `misalign_o`=0, `wb_count_o`=0.
- Internal state: `hold_valid`=0.
- Ready outputs read 1 while in reset.
- Reset asserted while the hold buffer is occupied drops the held entry; no write is issued after release.

**Hold and stall**
- The hold buffer is never overwritten while valid.
- The maximum stall is one cycle per collision.
- Back-to-back collisions alternate: the collision cycle, a drain cycle with both sources stalled, then the next acceptance.

## Test plan
- **ALU write:** `mem_valid_i=1`, rd=7, alu=0x1234_5678, not a load. Next cycle: `reg_wen_o=1`, `reg_waddr_o=7`, `reg_wdata_o=0x12345678`; `wb_count_o` goes 0→1.
- **Load extraction:** `mem_rdata_i=0x80F1_7F02`.
  - LB off=3 → 0xFFFFFF80.
  - LBU off=2 → 0x000000F1.
  - LH off=2 → 0xFFFF80F1.
  - LHU off=0 → 0x00007F02.
  - LW off=0 → 0x80F17F02.
- **Misaligned:**
  - LW off=1, rd=5 → no write, `misalign_o` pulses for one cycle, `wb_count_o` unchanged.
  - LH off=3 → same response.
- **Collision:** same cycle, MDU rd=3 data 0xA and ALU rd=4 data 0xB.
  - Cycle +1: write x3=0xA, both ready outputs low.
  - Cycle +2: write x4=0xB, both ready outputs high.
- **x0 and suppressed collision:** ALU rd=0 collides with MDU rd=9.
  - Only x9 is written.
  - `hold_valid` stays 0; ready outputs stay high.
  - `wb_count_o` increments by exactly 1.
- **Reset mid-hold:** create a collision, then assert `rst_n=0` asynchronously before the drain cycle.
  - All outputs go to 0 immediately.
  - After release, no write of the held entry occurs.
